// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with Gray-coded load, optional saturation,
// sticky overflow/underflow flags and a one-cycle terminal-event pulse.
module gray_counter_n #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned SATURATE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Terminal
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
    localparam bit               SAT_MODE = (SATURATE != 0);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             r_term;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_load_bin = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_load_bin = w_load_bin ^ (LoadGray >> k);
        end
    end

    assign w_at_max  = (r_cnt == MAX_VAL);
    assign w_at_zero = (r_cnt == ZERO_VAL);
    assign w_ovf_evt = En &  Dir & w_at_max;
    assign w_unf_evt = En & ~Dir & w_at_zero;

    // Step logic; in wrap mode the modulo arithmetic provides the wrap naturally
    always_comb begin
        w_cnt_next = r_cnt;
        if (En) begin
            if (Dir) begin
                if (!(w_at_max && SAT_MODE)) begin
                    w_cnt_next = r_cnt + ONE_VAL;
                end
            end else begin
                if (!(w_at_zero && SAT_MODE)) begin
                    w_cnt_next = r_cnt - ONE_VAL;
                end
            end
        end
    end

    // Reset > Load > En; a new event beats a simultaneous flag clear
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_term <= 1'b0;
        end else if (Load) begin
            r_cnt  <= w_load_bin;
            r_term <= 1'b0;
            if (ClrFlags) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
        end else begin
            r_cnt  <= w_cnt_next;
            r_term <= w_ovf_evt | w_unf_evt;
            r_ovf  <= w_ovf_evt | (r_ovf & ~ClrFlags);
            r_unf  <= w_unf_evt | (r_unf & ~ClrFlags);
        end
    end

    assign Output    = r_cnt ^ (r_cnt >> 1);
    assign Binary    = r_cnt;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Terminal  = r_term;

endmodule
